// File: rtl/decode_issue.sv
// decode_issue: decodes fetch instructions, reads operands, and issues them to execute.
// A per-register scoreboard stalls issue on RAW/WAW hazards against in-flight writes.
module decode_issue #(
    parameter int DATA_W = 16,
    parameter int REG_CNT = 16,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    output logic              in_ready,
    output logic [IDX_W-1:0]  rf_src1,
    output logic [IDX_W-1:0]  rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [IDX_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_wr,
    output logic              out_illegal,
    output logic [15:0]       stall_cnt
);
    logic [3:0] op;
    logic [IDX_W-1:0] rd;
    logic usesRs1, usesRs2, writesRd, illegal, hazard, accept;
    logic [REG_CNT-1:0] sb, busy, sbNext;

    assign op = in_instr[15:12];
    assign rd = in_instr[11:8];
    assign rf_src1 = in_instr[7:4];
    assign rf_src2 = in_instr[3:0];
    assign usesRs1 = op inside {[4'd1:4'd8]};
    assign usesRs2 = op inside {[4'd1:4'd4], 4'd7};
    assign writesRd = op inside {[4'd1:4'd6], 4'd8};
    assign illegal = op > 4'd8;
    // Writeback lands on the negedge, so its register is already safe to read this cycle.
    assign busy = sb & ~(wb_en ? REG_CNT'(1) << wb_dest : '0);
    assign hazard = (usesRs1 & busy[rf_src1]) | (usesRs2 & busy[rf_src2]) | (writesRd & busy[rd]);
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept = in_valid && in_ready;

    always_comb begin
        sbNext = busy;
        if (flush && out_valid && out_wr) sbNext[out_rd] = 1'b0;
        if (accept && writesRd) sbNext[rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
            stall_cnt <= '0;
            out_valid <= 1'b0;
            out_op <= '0;
            out_rd <= '0;
            out_a <= '0;
            out_b <= '0;
            out_wr <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            sb <= sbNext;
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (accept) begin
                out_valid <= 1'b1;
                out_op <= op;
                out_rd <= rd;
                out_a <= rf_data1;
                out_b <= op == 4'd5 ? {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]} : rf_data2;
                out_wr <= writesRd;
                out_illegal <= illegal;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that sits directly upstream of the 16×16 register file.
- Accepts 16-bit instructions from fetch over a valid/ready handshake.
- Drives register-file read indices and tracks pending writes in a scoreboard, stalling on RAW/WAW hazards.
- Latches decoded fields plus operand data into an output register consumed by execute.

Parameters:
- DATA_W, 16, operand/register width
- REG_CNT, 16, number of architectural registers
- IDX_W, 4, register index width (log2 REG_CNT)

Ports:
- clk input 1 system clock; register file writes on negedge, this block is posedge
- rst input 1 reset, asynchronous, active-high
- in_valid input 1 fetch presents instruction
- in_instr input 16 instruction word
- in_ready output 1 stage accepts in_instr this cycle
- rf_src1 output IDX_W read index 1 to register file (combinational from in_instr)
- rf_src2 output IDX_W read index 2 to register file
- rf_data1 input DATA_W register file read data 1
- rf_data2 input DATA_W register file read data 2
- wb_en input 1 writeback strobe (same signal as register file write enable)
- wb_dest input IDX_W writeback destination index
- flush input 1 kill the entry held in the output register
- out_valid output 1 decoded entry available
- out_ready input 1 execute consumes entry
- out_op output 4 opcode
- out_rd output IDX_W destination index
- out_a output DATA_W operand A (rf_data1)
- out_b output DATA_W operand B (rf_data2, or sign-extended imm for ADDI)
- out_wr output 1 entry writes out_rd
- out_illegal output 1 entry carried an undefined opcode
- stall_cnt output 16 saturating count of stalled cycles

Behaviour:
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4.
- rf_src1 = in_instr[7:4] and rf_src2 = in_instr[3:0], always driven.
- Opcode classes (uses_rs1 / uses_rs2 / writes_rd):
  - 0 NOP: 0/0/0
  - 1 ADD, 2 SUB, 3 AND, 4 OR: 1/1/1
  - 5 ADDI: 1/0/1, imm sign-extended to DATA_W
  - 6 LD: 1/0/1
  - 7 ST: 1/1/0
  - 8 MOV: 1/0/1
  - 9–F: illegal, decoded as 0/0/0 with out_illegal=1
- Scoreboard sb[REG_CNT], one busy bit per register.
  - Effective busy = sb & ~(wb_en ? onehot(wb_dest) : 0). A writeback clears the hazard in the same cycle, because the register file writes on negedge and read data is valid before the posedge.
- hazard = (uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd]).
- space = !out_valid | out_ready.
- in_ready = space & !hazard & !flush.
- Accept (in_valid & in_ready), at posedge:
  - out_valid ← 1; out_* fields loaded; out_a ← rf_data1; out_b ← rf_data2 or imm.
  - If writes_rd, sb[rd] ← 1.
- out_valid & out_ready with no accept: out_valid ← 0.
- sb update order per cycle: clear for wb first, then set for accept. Set wins on the same index.
- flush:
  - out_valid ← 0.
  - If the flushed entry had out_wr, clear sb[out_rd].
  - No accept this cycle.
  - Flush with out_valid=0 is a no-op besides blocking accept.
- Output fields hold stable while out_valid & !out_ready.
- stall_cnt increments when in_valid & !in_ready, saturating at 0xFFFF.
- wb_en with sb[wb_dest]=0 is ignored; no error.
- Latency: instruction accepted at edge N is visible on out_* after edge N. Throughput is 1/cycle absent hazards.
- Reset (asynchronous, any time, including mid-stall or mid-flush): sb=0, out_valid=0, all out_* = 0, stall_cnt=0. in_ready follows combinationally, i.e. 1 unless flush.

Test Plan:
- Reset then ADD r3,r1,r2 (0x1312), rf_data1=5, rf_data2=7, out_ready=1 → next cycle out_valid=1, out_op=1, out_rd=3, out_a=5, out_b=7, sb[3]=1.
- ADD r3,… then ADD r4,r3,r0 (0x1430) with no writeback → in_ready=0, stall_cnt counts 1,2,3. Pulse wb_en with wb_dest=3 → accepted that same cycle.
- ADDI r2,r1,-1 (0x521F) → out_b=0xFFFF, out_wr=1. ST r1,r2 (0x7012) → out_wr=0, sb unchanged.
- out_ready=0 with entry held and a new in_valid → in_ready=0, out_* stable. Raise out_ready → next instruction loads on the following edge.
- Entry MOV r5,r1 held, assert flush → out_valid=0, sb[5]=0, in_ready=0 that cycle. A following instruction reading r5 issues without stall.
- Opcode 0xA → out_illegal=1, out_wr=0. Assert rst mid-stall → sb=0, out_valid=0, stall_cnt=0 immediately.
